// File: rtl/cycle_control_if.sv
// -----------------------------------------------------------------------------
// cycle_control_if
// Bus between the instruction-cycle controller and its environment.
//
//   run                 : cycle-advance enable (only looked at in phase A1)
//   data[3:0]           : instruction bus nibble (OPR in M1, OPA in M2)
//   cycle[2:0]          : current phase, A1=0 .. X3=7
//   sync                : high while in phase A1
//   inst_operand[3:0]   : latched OPA
//   clear_carry, write_carry, clear_accumulator,
//   write_accumulator, write_register : one-clock datapath strobes in X3
//   acc_input_sel[2:0], reg_input_sel[1:0], alu_op[2:0],
//   alu_in0_sel[1:0], alu_in1_sel[1:0], alu_cin_sel[1:0] : datapath selects
//
// master : the side that drives run/data and consumes the decode outputs
// slave  : the controller itself
// -----------------------------------------------------------------------------
interface cycle_control_if;
    logic       run;
    logic [3:0] data;
    logic [2:0] cycle;
    logic       sync;
    logic [3:0] inst_operand;
    logic       clear_carry;
    logic       write_carry;
    logic       clear_accumulator;
    logic       write_accumulator;
    logic       write_register;
    logic [2:0] acc_input_sel;
    logic [1:0] reg_input_sel;
    logic [2:0] alu_op;
    logic [1:0] alu_in0_sel;
    logic [1:0] alu_in1_sel;
    logic [1:0] alu_cin_sel;

    modport master (
        output run, data,
        input  cycle, sync, inst_operand,
        input  clear_carry, write_carry, clear_accumulator,
        input  write_accumulator, write_register,
        input  acc_input_sel, reg_input_sel, alu_op,
        input  alu_in0_sel, alu_in1_sel, alu_cin_sel
    );

    modport slave (
        input  run, data,
        output cycle, sync, inst_operand,
        output clear_carry, write_carry, clear_accumulator,
        output write_accumulator, write_register,
        output acc_input_sel, reg_input_sel, alu_op,
        output alu_in0_sel, alu_in1_sel, alu_cin_sel
    );
endinterface

// File: rtl/cycle_control.sv
// -----------------------------------------------------------------------------
// cycle_control
// Eight-phase instruction-cycle sequencer and instruction decoder.
// The phase counter waits in A1 until run is high, then walks
// A2, A3, M1, M2, X1, X2, X3 and returns to A1. OPR is captured on the edge
// leaving M1 and OPA on the edge leaving M2; the decoded datapath selects are
// valid from X1 and the write strobes fire for the single X3 clock.
//
//   clock : sole clock, rising edge
//   reset : synchronous, active high; wins over run and over any phase
//   bus   : cycle_control_if.slave (see the interface file for signals)
// -----------------------------------------------------------------------------
package cycle_control_pkg;

    typedef enum logic [2:0] {
        A1 = 3'd0, A2 = 3'd1, A3 = 3'd2, M1 = 3'd3,
        M2 = 3'd4, X1 = 3'd5, X2 = 3'd6, X3 = 3'd7
    } cycle_e;

    // Accumulator write source
    localparam logic [2:0] ACC_IN_ALU   = 3'd0;
    localparam logic [2:0] ACC_IN_REG   = 3'd1;
    localparam logic [2:0] ACC_IN_IMM   = 3'd2;
    localparam logic [2:0] ACC_IN_CARRY = 3'd3;

    // Register-file write source
    localparam logic [1:0] REG_IN_ALU = 2'd0;
    localparam logic [1:0] REG_IN_ACC = 2'd1;

    // ALU function; every supported instruction is a plain adder with
    // operand/carry conditioning done by the input selects.
    localparam logic [2:0] ALU_ADD = 3'd0;

    localparam logic [1:0] IN0_ACC = 2'd0;
    localparam logic [1:0] IN0_REG = 2'd1;

    localparam logic [1:0] IN1_REG   = 2'd0;
    localparam logic [1:0] IN1_REG_N = 2'd1;
    localparam logic [1:0] IN1_ZERO  = 2'd2;
    localparam logic [1:0] IN1_ONE   = 2'd3;

    localparam logic [1:0] CIN_CARRY   = 2'd0;
    localparam logic [1:0] CIN_CARRY_N = 2'd1;
    localparam logic [1:0] CIN_ZERO    = 2'd2;
    localparam logic [1:0] CIN_ONE     = 2'd3;

endpackage

module cycle_control
    import cycle_control_pkg::*;
(
    input logic          clock,
    input logic          reset,
    cycle_control_if.slave bus
);

    cycle_e     cycle_q, cycle_d;
    logic [3:0] opr_q, opr_d;
    logic [3:0] opa_q, opa_d;

    // Decoded X3 actions before phase gating
    logic       dec_clear_carry;
    logic       dec_write_carry;
    logic       dec_clear_acc;
    logic       dec_write_acc;
    logic       dec_write_reg;
    logic       strobe_en;

    // -------------------------------------------------------------------------
    // State register
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= A1;
            opr_q   <= 4'h0;
            opa_q   <= 4'h0;
        end else begin
            cycle_q <= cycle_d;
            opr_q   <= opr_d;
            opa_q   <= opa_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // NOTE: every variable gets a default at the top so no path leaves it
    // unassigned, which would otherwise infer a latch.
    // -------------------------------------------------------------------------
    always_comb begin
        cycle_d = cycle_q;
        opr_d   = opr_q;
        opa_d   = opa_q;
        unique case (cycle_q)
            A1: if (bus.run) cycle_d = A2;   // run matters only here
            A2: cycle_d = A3;
            A3: cycle_d = M1;
            M1: begin
                cycle_d = M2;
                opr_d   = bus.data;
            end
            M2: begin
                cycle_d = X1;
                opa_d   = bus.data;
            end
            X1: cycle_d = X2;
            X2: cycle_d = X3;
            X3: cycle_d = A1;
            default: cycle_d = A1;
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: instruction decode from the latched OPR/OPA
    // -------------------------------------------------------------------------
    always_comb begin
        dec_clear_carry   = 1'b0;
        dec_write_carry   = 1'b0;
        dec_clear_acc     = 1'b0;
        dec_write_acc     = 1'b0;
        dec_write_reg     = 1'b0;
        bus.acc_input_sel = ACC_IN_ALU;
        bus.reg_input_sel = REG_IN_ALU;
        bus.alu_op        = ALU_ADD;
        bus.alu_in0_sel   = IN0_ACC;
        bus.alu_in1_sel   = IN1_REG;
        bus.alu_cin_sel   = CIN_CARRY;
        case (opr_q)
            4'hD: begin                        // LDM
                dec_write_acc     = 1'b1;
                bus.acc_input_sel = ACC_IN_IMM;
            end
            4'hA: begin                        // LD
                dec_write_acc     = 1'b1;
                bus.acc_input_sel = ACC_IN_REG;
            end
            4'hB: begin                        // XCH: both writes on one edge
                dec_write_acc     = 1'b1;
                bus.acc_input_sel = ACC_IN_REG;
                dec_write_reg     = 1'b1;
                bus.reg_input_sel = REG_IN_ACC;
            end
            4'h8: begin                        // ADD: acc + reg + carry
                dec_write_acc     = 1'b1;
                dec_write_carry   = 1'b1;
                bus.acc_input_sel = ACC_IN_ALU;
                bus.alu_in0_sel   = IN0_ACC;
                bus.alu_in1_sel   = IN1_REG;
                bus.alu_cin_sel   = CIN_CARRY;
            end
            4'h9: begin                        // SUB: acc + ~reg + ~carry
                dec_write_acc     = 1'b1;
                dec_write_carry   = 1'b1;
                bus.acc_input_sel = ACC_IN_ALU;
                bus.alu_in0_sel   = IN0_ACC;
                bus.alu_in1_sel   = IN1_REG_N;
                bus.alu_cin_sel   = CIN_CARRY_N;
            end
            4'h6: begin                        // INC: reg + 1, carry untouched
                dec_write_reg     = 1'b1;
                bus.reg_input_sel = REG_IN_ALU;
                bus.alu_in0_sel   = IN0_REG;
                bus.alu_in1_sel   = IN1_ONE;
                bus.alu_cin_sel   = CIN_ZERO;
            end
            4'hF: begin
                case (opa_q)
                    4'h0: begin                // CLB
                        dec_clear_acc   = 1'b1;
                        dec_clear_carry = 1'b1;
                    end
                    4'h1: dec_clear_carry = 1'b1;  // CLC
                    4'h7: begin                // TCC: acc <= carry, then clear
                        dec_write_acc     = 1'b1;
                        bus.acc_input_sel = ACC_IN_CARRY;
                        dec_clear_carry   = 1'b1;
                    end
                    default: ;                 // unsupported: NOP
                endcase
            end
            default: ;                         // includes the reset value 0/0
        endcase
    end

    // Strobes exist only in X3; a reset arriving in that same clock squashes
    // them so the datapath never commits on the edge that resets the cycle.
    assign strobe_en = (cycle_q == X3) && !reset;

    assign bus.clear_carry       = strobe_en & dec_clear_carry;
    assign bus.write_carry       = strobe_en & dec_write_carry;
    assign bus.clear_accumulator = strobe_en & dec_clear_acc;
    assign bus.write_accumulator = strobe_en & dec_write_acc;
    assign bus.write_register    = strobe_en & dec_write_reg;

    assign bus.cycle        = cycle_q;
    assign bus.sync         = (cycle_q == A1);
    assign bus.inst_operand = opa_q;

endmodule

// File: tb/tb_cycle_control.sv
// -----------------------------------------------------------------------------
// tb_cycle_control
// Directed self-checking bench for cycle_control. Strobes are viewed as one
// vector {clear_carry, write_carry, clear_accumulator, write_accumulator,
// write_register}; select encodings are restated locally.
// -----------------------------------------------------------------------------
module tb_cycle_control;

    localparam logic [2:0] ACC_ALU = 3'd0, ACC_REG = 3'd1, ACC_IMM = 3'd2, ACC_CARRY = 3'd3;
    localparam logic [1:0] REG_ALU = 2'd0, REG_ACC = 2'd1;
    // {alu_op, in0, in1, cin}
    localparam logic [8:0] ALU_SEL_ADD = {3'd0, 2'd0, 2'd0, 2'd0};
    localparam logic [8:0] ALU_SEL_SUB = {3'd0, 2'd0, 2'd1, 2'd1};
    localparam logic [8:0] ALU_SEL_INC = {3'd0, 2'd1, 2'd3, 2'd2};

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    cycle_control_if bus ();

    cycle_control dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [4:0] stb;
    logic [8:0] alu_sel;
    assign stb = {bus.clear_carry, bus.write_carry, bus.clear_accumulator,
                  bus.write_accumulator, bus.write_register};
    assign alu_sel = {bus.alu_op, bus.alu_in0_sel, bus.alu_in1_sel, bus.alu_cin_sel};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Run one full instruction from A1 and check every phase of interest.
    task automatic exec(input string name, input logic [3:0] opr, input logic [3:0] opa,
                        input logic [4:0] exp_stb,
                        input bit chk_acc, input logic [2:0] exp_acc,
                        input bit chk_reg, input logic [1:0] exp_reg,
                        input bit chk_alu, input logic [8:0] exp_alu);
        check({name, " A1 cycle"}, bus.cycle, 0);
        check({name, " A1 sync"}, bus.sync, 1);
        bus.run = 1'b1;
        step();                                  // A2
        bus.run = 1'b0;                          // ignored from here on
        check({name, " A2 cycle"}, bus.cycle, 1);
        check({name, " A2 sync"}, bus.sync, 0);
        step();                                  // A3
        step();                                  // M1
        check({name, " M1 cycle"}, bus.cycle, 3);
        bus.data = opr;
        step();                                  // M2
        bus.data = opa;
        step();                                  // X1
        bus.data = ~opa;                         // operand must stay latched
        check({name, " X1 cycle"}, bus.cycle, 5);
        check({name, " X1 operand"}, bus.inst_operand, opa);
        check({name, " X1 strobes"}, stb, 0);
        step();                                  // X2
        check({name, " X2 strobes"}, stb, 0);
        step();                                  // X3
        check({name, " X3 cycle"}, bus.cycle, 7);
        check({name, " X3 strobes"}, stb, exp_stb);
        check({name, " X3 operand"}, bus.inst_operand, opa);
        if (chk_acc) check({name, " X3 acc_sel"}, bus.acc_input_sel, exp_acc);
        if (chk_reg) check({name, " X3 reg_sel"}, bus.reg_input_sel, exp_reg);
        if (chk_alu) check({name, " X3 alu_sel"}, alu_sel, exp_alu);
        step();                                  // back to A1
        check({name, " next A1 cycle"}, bus.cycle, 0);
        check({name, " next A1 sync"}, bus.sync, 1);
        check({name, " next A1 strobes"}, stb, 0);
    endtask

    initial begin
        reset    = 1'b1;
        bus.run  = 1'b0;
        bus.data = 4'h0;

        // Reset for two clocks, then idle with run low.
        step();
        step();
        check("reset cycle", bus.cycle, 0);
        check("reset sync", bus.sync, 1);
        check("reset strobes", stb, 0);
        check("reset operand", bus.inst_operand, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle cycle", bus.cycle, 0);
            check("idle sync", bus.sync, 1);
            check("idle strobes", stb, 0);
        end

        //   name    OPR   OPA   strobes   acc?  acc sel    reg?  reg sel  alu?  alu sel
        exec("LDM", 4'hD, 4'h5, 5'b00010, 1'b1, ACC_IMM,   1'b0, REG_ALU, 1'b0, ALU_SEL_ADD);
        exec("ADD", 4'h8, 4'h3, 5'b01010, 1'b1, ACC_ALU,   1'b0, REG_ALU, 1'b1, ALU_SEL_ADD);
        exec("XCH", 4'hB, 4'h9, 5'b00011, 1'b1, ACC_REG,   1'b1, REG_ACC, 1'b0, ALU_SEL_ADD);
        exec("NOP24", 4'h2, 4'h4, 5'b00000, 1'b0, ACC_ALU, 1'b0, REG_ALU, 1'b0, ALU_SEL_ADD);
        exec("LD",  4'hA, 4'hC, 5'b00010, 1'b1, ACC_REG,   1'b0, REG_ALU, 1'b0, ALU_SEL_ADD);
        exec("SUB", 4'h9, 4'h2, 5'b01010, 1'b1, ACC_ALU,   1'b0, REG_ALU, 1'b1, ALU_SEL_SUB);
        exec("INC", 4'h6, 4'h7, 5'b00001, 1'b0, ACC_ALU,   1'b1, REG_ALU, 1'b1, ALU_SEL_INC);
        exec("CLB", 4'hF, 4'h0, 5'b10100, 1'b0, ACC_ALU,   1'b0, REG_ALU, 1'b0, ALU_SEL_ADD);
        exec("CLC", 4'hF, 4'h1, 5'b10000, 1'b0, ACC_ALU,   1'b0, REG_ALU, 1'b0, ALU_SEL_ADD);
        exec("TCC", 4'hF, 4'h7, 5'b10010, 1'b1, ACC_CARRY, 1'b0, REG_ALU, 1'b0, ALU_SEL_ADD);
        exec("NOPF2", 4'hF, 4'h2, 5'b00000, 1'b0, ACC_ALU, 1'b0, REG_ALU, 1'b0, ALU_SEL_ADD);

        // Reset in M2 in the middle of an ADD.
        bus.run = 1'b1;
        step();                                  // A2
        bus.run = 1'b0;
        step();                                  // A3
        step();                                  // M1
        bus.data = 4'h8;
        step();                                  // M2
        check("midreset M2 cycle", bus.cycle, 4);
        bus.data = 4'h3;
        reset    = 1'b1;
        step();
        check("midreset cycle", bus.cycle, 0);
        check("midreset operand", bus.inst_operand, 0);
        check("midreset strobes", stb, 0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check("postreset idle cycle", bus.cycle, 0);
            check("postreset idle strobes", stb, 0);
        end
        exec("ADD2", 4'h8, 4'h3, 5'b01010, 1'b1, ACC_ALU, 1'b0, REG_ALU, 1'b1, ALU_SEL_ADD);

        // Reset arriving in X3 squashes that clock's strobes.
        bus.run = 1'b1;
        step();                                  // A2
        bus.run = 1'b0;
        step();                                  // A3
        step();                                  // M1
        bus.data = 4'hD;
        step();                                  // M2
        bus.data = 4'h6;
        step();                                  // X1
        step();                                  // X2
        step();                                  // X3
        check("x3reset pre strobes", stb, 5'b00010);
        reset = 1'b1;
        #1;
        check("x3reset squashed strobes", stb, 0);
        step();
        check("x3reset cycle", bus.cycle, 0);
        check("x3reset operand", bus.inst_operand, 0);
        check("x3reset strobes", stb, 0);
        reset = 1'b0;

        exec("LDM2", 4'hD, 4'hA, 5'b00010, 1'b1, ACC_IMM, 1'b0, REG_ALU, 1'b0, ALU_SEL_ADD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cycle_control.md
CYCLE_CONTROL -- requirements
Module: cycle_control

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock; all state changes on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-003 run  in  1  cycle-advance enable, sampled only in state A1.
REQ-004 data  in  4  instruction bus nibble.
REQ-005 cycle  out  3  current phase: A1=0 A2=1 A3=2 M1=3 M2=4 X1=5 X2=6 X3=7.
REQ-006 sync  out  1  high during A1 only.
REQ-007 inst_operand  out  4  latched OPA.
REQ-008 clear_carry, write_carry, clear_accumulator, write_accumulator, write_register  out  1 each  datapath write strobes.
REQ-009 acc_input_sel  out  3; reg_input_sel  out  2; alu_op  out  3; alu_in0_sel, alu_in1_sel, alu_cin_sel  out  2 each. All use the shared datapath/ALU header encodings.

Function
REQ-010 Phase counter SHALL step A1->A2->...->X3->A1, one phase per clock.
REQ-011 In A1 with run=0 the counter SHALL hold at A1; with run=1 it SHALL advance to A2 next clock.
REQ-012 run SHALL be ignored in all phases other than A1; a started cycle always completes.
REQ-013 On the clock edge leaving M1, OPR SHALL be latched from data.
REQ-014 On the clock edge leaving M2, OPA SHALL be latched from data; inst_operand = OPA, stable until the next M2.
REQ-015 Write strobes SHALL be high only in X3, for exactly one clock; low in all other phases.
REQ-016 Selects and alu_op SHALL be decoded combinationally from the latched OPR/OPA, valid X1..X3. Unused selects SHALL be don't-care.
REQ-017 Decode (OPR, OPA) -> X3 action:
- LDM (D,n): write_accumulator, acc from IMM.
- LD (A,r): write_accumulator, acc from REG.
- XCH (B,r): write_accumulator from REG plus write_register from ACC, in the same clock.
- ADD (8,r): ALU acc+reg+carry; write_accumulator from ALU; write_carry.
- SUB (9,r): ALU acc+~reg+~carry; write_accumulator from ALU; write_carry.
- INC (6,r): ALU reg+1, cin=0; write_register from ALU; no carry write.
- CLB (F,0): clear_accumulator plus clear_carry.
- CLC (F,1): clear_carry.
- TCC (F,7): write_accumulator from CARRY plus clear_carry.
REQ-018 Any other opcode SHALL act as NOP: no strobe asserted in X3.
REQ-019 The decoder SHALL never assert clear_* and write_* for the same target together.

Reset
REQ-020 reset=1 SHALL force, next clock: cycle=A1, OPR=OPA=0, all strobes 0, sync=1.
REQ-021 OPR=OPA=0 SHALL decode as NOP.
REQ-022 reset SHALL take priority over run and over any phase, including mid-cycle and X3.
REQ-023 A reset asserted in X3 SHALL suppress that clock's strobes.
REQ-024 After reset deassertion, operation SHALL resume from A1 under REQ-011.

Verification
REQ-025 reset 2 clocks, run=0 for 5 clocks -> cycle=0, sync=1, no strobes throughout.
REQ-026 run=1; data M1=D, M2=5 -> inst_operand=5 from X1; in X3 only write_accumulator=1 with acc_input_sel=IMM; sync high again 8 clocks after leaving A1.
REQ-027 ADD r3: data 8/3 -> X3: write_accumulator, write_carry, ALU add selects, inst_operand=3; strobes low in X1/X2 and the next A1.
REQ-028 XCH r9: data B/9 -> X3: write_accumulator (REG) and write_register (ACC) in the same clock.
REQ-029 Data 2/4 (unsupported) -> no strobes in X3; counter continues normally.
REQ-030 reset asserted in M2 during an ADD -> next clock cycle=A1 with no strobe ever asserted; with run=1, next instruction executes normally.
